eth_link_watchdog: RTL and testbench
====================================

Name: eth_link_watchdog

Overview:
- Free-running supervisor for the 10G QSFP lane.
- Watches RX reset-done, block lock and high-BER from the GT/PCS, and reports a debounced link_up.
- Re-pulses the GT wizard RX datapath reset (gtwiz_reset_rx_datapath_in) when lock is not reached, or is lost, within a timeout.
- Sits directly upstream of the GT wizard reset inputs and beside the 10G PHY; all logic runs on the 125 MHz free-running clock.

Parameters:
- LOCK_TIMEOUT_CYCLES, 12500000, clk cycles (100 ms) allowed from reset-done to stable lock, or for lock recovery.
- LOCK_STABLE_CYCLES, 1024, consecutive cycles lock must hold before link_up asserts.
- RESET_PULSE_CYCLES, 16, width of the rx_datapath_reset pulse.
- SYNC_STAGES, 3, flip-flops per input synchronizer (>=2).
- RETRY_CNT_WIDTH, 8, width of retry_count (saturating).

Ports:
- clk_125mhz_int  in  1  free-running 125 MHz clock
- gt_tx_reset  in  1  asynchronous, active-high reset
- enable  in  1  watchdog enable, synchronous to clk_125mhz_int
- rx_reset_done_async  in  1  gtwiz_reset_rx_done_out, rx domain
- rx_block_lock_async  in  1  PCS block lock, rx_clk domain
- rx_high_ber_async  in  1  PCS high-BER flag, rx_clk domain
- rx_datapath_reset  out  1  to gtwiz_reset_rx_datapath_in
- link_up  out  1  debounced link status
- retry_count  out  RETRY_CNT_WIDTH  datapath resets issued, saturating
- state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset gt_tx_reset is asynchronous, active-high; clock is clk_125mhz_int.
- Reset values:
  - rx_datapath_reset=0, link_up=0, retry_count=0, state=IDLE.
  - timer=0, stable counter=0.
  - Synchronizer flops=0.
- Inputs: each *_async passes through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency. All decisions use the synchronized values (done_s, lock_s, ber_s).
- FSM states and encodings: IDLE=0, WAIT_DONE=1, WAIT_LOCK=2, LINK_UP=3, RESET=4.
- IDLE:
  - Outputs quiet.
  - enable=1 -> WAIT_DONE.
- WAIT_DONE:
  - timer counts up.
  - done_s=1 -> WAIT_LOCK, timer cleared.
  - timer reaches LOCK_TIMEOUT_CYCLES-1 -> RESET.
- WAIT_LOCK:
  - timer counts up.
  - stable counter increments while lock_s=1 and ber_s=0; otherwise it clears.
  - stable counter reaches LOCK_STABLE_CYCLES-1 -> LINK_UP; link_up=1 on the following cycle.
  - timer reaches LOCK_TIMEOUT_CYCLES-1 -> RESET.
  - If the timeout and the stable-count completion occur in the same cycle, LINK_UP wins.
- LINK_UP:
  - link_up=1.
  - lock_s=0 or ber_s=1 -> WAIT_LOCK; link_up deasserts the next cycle; timer and stable counter cleared.
- RESET:
  - rx_datapath_reset=1 for exactly RESET_PULSE_CYCLES cycles.
  - retry_count increments once on entry, saturating at all-ones.
  - On pulse end -> WAIT_DONE, timer cleared.
- enable=0 in any state -> IDLE next cycle.
  - If that happens mid-RESET, the pulse is truncated and rx_datapath_reset drops the same cycle as the state change.
  - enable=0 has priority over all other transitions.
- done_s falling in WAIT_LOCK or LINK_UP -> WAIT_DONE; link_up clears and the timer is cleared.
- Timer width: $clog2(LOCK_TIMEOUT_CYCLES+1). No wrap is possible because the timer always clears on a state change.
- All outputs are registered.
- An asserted reset mid-pulse drops rx_datapath_reset immediately (asynchronous).

Optional Feature:
- Macro ETH_LINK_WATCHDOG_STATS_EN.
- When defined:
  - Adds output link_drop_count [15:0], which counts LINK_UP->WAIT_LOCK transitions, saturating, reset 0.
  - Adds output last_lock_time [31:0], which latches the timer value on each WAIT_LOCK->LINK_UP transition (time-to-lock in cycles), reset 0.
- When undefined: neither port nor its logic exists; the rest of the behaviour is identical.

Decomposition:
- Shared package eth_link_pkg holds:
  - The state enum (IDLE..RESET, 3-bit).
  - Default timing constants (LOCK_TIMEOUT_100MS=12500000, LOCK_STABLE_DEFAULT=1024).
- One sub-module, eth_sync_bit: a parameterized SYNC_STAGES flop chain with ASYNC_REG attribute and asynchronous clear. It is instantiated three times.

Test Plan:
All scenarios use LOCK_TIMEOUT_CYCLES=100, LOCK_STABLE_CYCLES=8, RESET_PULSE_CYCLES=4, SYNC_STAGES=2.
- Clean bring-up:
  - Stimulus: enable=1; done=1 at cycle 5; lock=1 at cycle 20 and held.
  - Required: link_up=1 at 20+2+8+1 cycles (±1 for the registered transition); retry_count=0; rx_datapath_reset never asserted.
- No lock:
  - Stimulus: done=1, lock=0 forever.
  - Required: rx_datapath_reset high for exactly 4 cycles after 100 cycles in WAIT_LOCK; retry_count=1, then 2 after the next period.
- Glitchy lock:
  - Stimulus: lock toggles with period 6.
  - Required: link_up stays 0; a reset pulse is issued at timeout.
- Lock loss:
  - Stimulus: in LINK_UP, drop lock for 3 cycles.
  - Required: link_up falls 2+1 cycles later; link_up re-asserts after 8 stable cycles; no reset pulse; link_drop_count=1 when the macro is defined.
- Disable mid-pulse:
  - Stimulus: enable=0 during the 2nd cycle of a RESET pulse.
  - Required: rx_datapath_reset=0 next cycle; state=0.
- Async reset:
  - Stimulus: assert gt_tx_reset mid-LINK_UP.
  - Required: link_up=0 and retry_count=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/eth_link_pkg.sv
// Shared types and default timing for the 10G link watchdog.
package eth_link_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StWaitDone = 3'd1,
    StWaitLock = 3'd2,
    StLinkUp   = 3'd3,
    StReset    = 3'd4
  } link_state_e;

  localparam int unsigned LOCK_TIMEOUT_100MS  = 12500000;
  localparam int unsigned LOCK_STABLE_DEFAULT = 1024;

endpackage

// File: rtl/eth_sync_bit.sv
// Single-bit multi-flop synchronizer with asynchronous active-high clear.
module eth_sync_bit #(
  parameter int unsigned SYNC_STAGES = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/eth_link_watchdog.sv
// GT RX link supervisor: debounced link_up and datapath-reset retries on lock timeout.
// Optional stats outputs are built when ETH_LINK_WATCHDOG_STATS_EN is defined.
module eth_link_watchdog
  import eth_link_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT_CYCLES = LOCK_TIMEOUT_100MS,
  parameter int unsigned LOCK_STABLE_CYCLES  = LOCK_STABLE_DEFAULT,
  parameter int unsigned RESET_PULSE_CYCLES  = 16,
  parameter int unsigned SYNC_STAGES         = 3,
  parameter int unsigned RETRY_CNT_WIDTH     = 8
) (
  input  logic                       clk_125mhz_int,
  input  logic                       gt_tx_reset,
  input  logic                       enable,
  input  logic                       rx_reset_done_async,
  input  logic                       rx_block_lock_async,
  input  logic                       rx_high_ber_async,
  output logic                       rx_datapath_reset,
  output logic                       link_up,
  output logic [RETRY_CNT_WIDTH-1:0] retry_count,
  output logic [2:0]                 state
`ifdef ETH_LINK_WATCHDOG_STATS_EN
  ,
  output logic [15:0]                link_drop_count,
  output logic [31:0]                last_lock_time
`endif
);

  localparam int unsigned TimerW  = $clog2(LOCK_TIMEOUT_CYCLES + 1);
  localparam int unsigned StableW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam logic [TimerW-1:0]  TimeoutLast = TimerW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [TimerW-1:0]  PulseLast   = TimerW'(RESET_PULSE_CYCLES - 1);
  localparam logic [StableW-1:0] StableLast  = StableW'(LOCK_STABLE_CYCLES - 1);

  logic done_s, lock_s, ber_s, lock_good;

  eth_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
    .clk_i (clk_125mhz_int),
    .rst_i (gt_tx_reset),
    .d_i   (rx_reset_done_async),
    .q_o   (done_s)
  );

  eth_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
    .clk_i (clk_125mhz_int),
    .rst_i (gt_tx_reset),
    .d_i   (rx_block_lock_async),
    .q_o   (lock_s)
  );

  eth_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ber (
    .clk_i (clk_125mhz_int),
    .rst_i (gt_tx_reset),
    .d_i   (rx_high_ber_async),
    .q_o   (ber_s)
  );

  assign lock_good = lock_s & ~ber_s;

  link_state_e                state_q, state_d;
  logic [TimerW-1:0]          timer_q, timer_d;
  logic [StableW-1:0]         stable_q, stable_d;
  logic [RETRY_CNT_WIDTH-1:0] retry_q, retry_d;
  logic                       link_up_q, link_up_d;
  logic                       dp_reset_q, dp_reset_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StWaitDone;
      end
      StWaitDone: begin
        if (done_s)                      state_d = StWaitLock;
        else if (timer_q == TimeoutLast) state_d = StReset;
      end
      StWaitLock: begin
        // Stable-count completion beats a simultaneous timeout.
        if (!done_s)                                    state_d = StWaitDone;
        else if (lock_good && (stable_q == StableLast)) state_d = StLinkUp;
        else if (timer_q == TimeoutLast)                state_d = StReset;
      end
      StLinkUp: begin
        if (!done_s)         state_d = StWaitDone;
        else if (!lock_good) state_d = StWaitLock;
      end
      StReset: begin
        if (timer_q == PulseLast) state_d = StWaitDone;
      end
      default: state_d = StIdle;
    endcase
    if (!enable) state_d = StIdle;
  end

  always_comb begin
    timer_d = '0;
    if ((state_d == state_q) &&
        (state_q inside {StWaitDone, StWaitLock, StReset})) begin
      timer_d = timer_q + 1'b1;
    end

    stable_d = '0;
    if ((state_q == StWaitLock) && (state_d == StWaitLock) && lock_good) begin
      stable_d = stable_q + 1'b1;
    end

    retry_d = retry_q;
    if ((state_d == StReset) && (state_q != StReset) && (retry_q != '1)) begin
      retry_d = retry_q + 1'b1;
    end

    // Outputs follow the next state so they change on the same edge as the FSM.
    link_up_d  = (state_d == StLinkUp);
    dp_reset_d = (state_d == StReset);
  end

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      stable_q   <= '0;
      retry_q    <= '0;
      link_up_q  <= 1'b0;
      dp_reset_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      stable_q   <= stable_d;
      retry_q    <= retry_d;
      link_up_q  <= link_up_d;
      dp_reset_q <= dp_reset_d;
    end
  end

  assign rx_datapath_reset = dp_reset_q;
  assign link_up           = link_up_q;
  assign retry_count       = retry_q;
  assign state             = state_q;

`ifdef ETH_LINK_WATCHDOG_STATS_EN
  logic [15:0] drop_q, drop_d;
  logic [31:0] lock_time_q, lock_time_d;

  always_comb begin
    drop_d = drop_q;
    if ((state_q == StLinkUp) && (state_d == StWaitLock) && (drop_q != '1)) begin
      drop_d = drop_q + 1'b1;
    end
    lock_time_d = lock_time_q;
    if ((state_q == StWaitLock) && (state_d == StLinkUp)) begin
      lock_time_d = 32'(timer_q);
    end
  end

  always_ff @(posedge clk_125mhz_int or posedge gt_tx_reset) begin
    if (gt_tx_reset) begin
      drop_q      <= '0;
      lock_time_q <= '0;
    end else begin
      drop_q      <= drop_d;
      lock_time_q <= lock_time_d;
    end
  end

  assign link_drop_count = drop_q;
  assign last_lock_time  = lock_time_q;
`else
  // Stats counters not built in this configuration.
`endif

endmodule

// File: tb/tb_eth_link_watchdog.sv
// Directed, table-driven bench for eth_link_watchdog with small test timings.
module tb_eth_link_watchdog;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0, done = 1'b0, lock = 1'b0, ber = 1'b0;
  logic       dp_rst, lup;
  logic [7:0] retry;
  logic [2:0] st;
`ifdef ETH_LINK_WATCHDOG_STATS_EN
  logic [15:0] drops;
  logic [31:0] lock_time;
`endif

  int checks = 0;
  int errors = 0;
  int rst_hi_cycles = 0;

  always #4 clk = ~clk;

  eth_link_watchdog #(
    .LOCK_TIMEOUT_CYCLES (100),
    .LOCK_STABLE_CYCLES  (8),
    .RESET_PULSE_CYCLES  (4),
    .SYNC_STAGES         (2),
    .RETRY_CNT_WIDTH     (8)
  ) dut (
    .clk_125mhz_int      (clk),
    .gt_tx_reset         (rst),
    .enable              (en),
    .rx_reset_done_async (done),
    .rx_block_lock_async (lock),
    .rx_high_ber_async   (ber),
    .rx_datapath_reset   (dp_rst),
    .link_up             (lup),
    .retry_count         (retry),
    .state               (st)
`ifdef ETH_LINK_WATCHDOG_STATS_EN
    ,
    .link_drop_count     (drops),
    .last_lock_time      (lock_time)
`endif
  );

  always @(negedge clk) if (dp_rst === 1'b1) rst_hi_cycles++;

  typedef struct {
    logic       en, done, lock, ber;
    int         cycles;
    logic [2:0] st;
    logic       lup, rst;
    logic [7:0] retry;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outs(input string name, input logic [2:0] e_st, input logic e_lup,
                            input logic e_rst, input logic [7:0] e_retry);
    checks++;
    if (st !== e_st || lup !== e_lup || dp_rst !== e_rst || retry !== e_retry) begin
      errors++;
      $display("FAIL %s: got st=%0d link_up=%b dp_rst=%b retry=%0d, expected st=%0d link_up=%b dp_rst=%b retry=%0d",
               name, st, lup, dp_rst, retry, e_st, e_lup, e_rst, e_retry);
    end
  endtask

  vec_t vecs[28];
  int   bad_glitch;
  int   waited;

  initial begin
    //          en done lock ber cyc  st lup rst retry
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0,  3, 3'd0, 1'b0, 1'b0, 8'd0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b0, 8'd0};
    vecs[2]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 3'd1, 1'b0, 1'b0, 8'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b0,  2, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b0,  7, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b0,  5, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b0,  2, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[10] = '{1'b1, 1'b1, 1'b1, 1'b0,  9, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b1,  2, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[13] = '{1'b1, 1'b1, 1'b1, 1'b1,  1, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b0,  9, 3'd2, 1'b0, 1'b0, 8'd0};
    vecs[15] = '{1'b1, 1'b1, 1'b1, 1'b0,  1, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 1'b0,  2, 3'd3, 1'b1, 1'b0, 8'd0};
    vecs[17] = '{1'b1, 1'b0, 1'b1, 1'b0,  1, 3'd1, 1'b0, 1'b0, 8'd0};
    vecs[18] = '{1'b1, 1'b0, 1'b1, 1'b0, 99, 3'd1, 1'b0, 1'b0, 8'd0};
    vecs[19] = '{1'b1, 1'b0, 1'b1, 1'b0,  1, 3'd4, 1'b0, 1'b1, 8'd1};
    vecs[20] = '{1'b1, 1'b0, 1'b1, 1'b0,  3, 3'd4, 1'b0, 1'b1, 8'd1};
    vecs[21] = '{1'b1, 1'b0, 1'b1, 1'b0,  1, 3'd1, 1'b0, 1'b0, 8'd1};
    vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0,  3, 3'd2, 1'b0, 1'b0, 8'd1};
    vecs[23] = '{1'b1, 1'b1, 1'b0, 1'b0, 99, 3'd2, 1'b0, 1'b0, 8'd1};
    vecs[24] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd4, 1'b0, 1'b1, 8'd2};
    vecs[25] = '{1'b1, 1'b1, 1'b0, 1'b0,  3, 3'd4, 1'b0, 1'b1, 8'd2};
    vecs[26] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd1, 1'b0, 1'b0, 8'd2};
    vecs[27] = '{1'b1, 1'b1, 1'b0, 1'b0,  1, 3'd2, 1'b0, 1'b0, 8'd2};

    #2 rst = 1'b1;
    #1 check_outs("reset_state", 3'd0, 1'b0, 1'b0, 8'd0);
    repeat (2) tick();
    rst = 1'b0;

    // Bring-up, lock loss, high-BER, done loss, and both timeout kinds.
    for (int i = 0; i < 28; i++) begin
      en   = vecs[i].en;
      done = vecs[i].done;
      lock = vecs[i].lock;
      ber  = vecs[i].ber;
      repeat (vecs[i].cycles) tick();
      check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].lup, vecs[i].rst, vecs[i].retry);
    end

    // Lock toggling with period 6 never qualifies; timeout fires after 100 cycles.
    bad_glitch = 0;
    for (int i = 0; i < 99; i++) begin
      lock = ((i / 3) % 2 == 0);
      tick();
      if (lup !== 1'b0 || st !== 3'd2 || dp_rst !== 1'b0) bad_glitch++;
    end
    check("glitch_no_link", bad_glitch, 0);
    tick();
    check_outs("glitch_timeout", 3'd4, 1'b0, 1'b1, 8'd3);

    // Disable during the second pulse cycle truncates the pulse.
    tick();
    check_outs("pulse_cycle2", 3'd4, 1'b0, 1'b1, 8'd3);
    en   = 1'b0;
    lock = 1'b1;
    tick();
    check_outs("disable_mid_pulse", 3'd0, 1'b0, 1'b0, 8'd3);
    check("reset_pulse_cycles", rst_hi_cycles, 10);

    // Re-enable with done/lock already up: link in 10 cycles.
    en = 1'b1;
    waited = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      waited++;
      if (lup === 1'b1) break;
    end
    check("relink_cycles", waited, 10);
    check_outs("relink_state", 3'd3, 1'b1, 1'b0, 8'd3);
`ifdef ETH_LINK_WATCHDOG_STATS_EN
    check("link_drop_count", drops, 2);
    check("last_lock_time", lock_time, 7);
`endif

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    #2 rst = 1'b1;
    #1 check_outs("async_reset", 3'd0, 1'b0, 1'b0, 8'd0);
    tick();
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
